// File: rtl/pirdsp_mac_pkg.sv
// Shared types and width helpers for the tiled PIRDSP multiply-accumulate pipeline.
package pirdsp_mac_pkg;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_DOT  = 1'b1;

    function automatic int full_w(input int sub_w, input int tiles);
        return sub_w * tiles;
    endfunction

    function automatic int prod_w(input int sub_w, input int tiles);
        return 2 * full_w(sub_w, tiles);
    endfunction

    // Lane sum needs headroom of clog2(lanes) over a single 2*SUB_W product.
    function automatic int dot_w(input int sub_w, input int tiles);
        return 2 * sub_w + $clog2(tiles * tiles);
    endfunction

    typedef struct packed {
        logic valid;
        logic mode;
        logic a_sign;
        logic b_sign;
        logic acc_en;
        logic acc_clear;
    } stage_ctrl_t;

endpackage

// File: rtl/pirdsp_mul_sub.sv
// Combinational SUB_W x SUB_W multiplier; each operand is independently signed or unsigned.
// The 2*SUB_W result is signed if either operand is signed, otherwise unsigned.
module pirdsp_mul_sub #(
    parameter int SUB_W = 9
) (
    input  logic [SUB_W-1:0]   x,
    input  logic [SUB_W-1:0]   y,
    input  logic               x_sign,
    input  logic               y_sign,
    output logic [2*SUB_W-1:0] p
);

    logic signed [SUB_W:0]     xs;
    logic signed [SUB_W:0]     ys;
    logic signed [2*SUB_W+1:0] prod;

    // One guard bit turns either interpretation into a signed operand; the exact
    // product always fits back into 2*SUB_W bits.
    assign xs   = {x_sign & x[SUB_W-1], x};
    assign ys   = {y_sign & y[SUB_W-1], y};
    assign prod = xs * ys;
    assign p    = prod[2*SUB_W-1:0];

endmodule

// File: rtl/pirdsp_mac_tiled_pipe.sv
// Tiled multiplier (one wide product or TILES^2-lane dot product) with accumulator and sticky overflow.
// Three register stages, 1 beat/cycle; an unaccepted output freezes every stage and deasserts in_ready.
module pirdsp_mac_tiled_pipe
    import pirdsp_mac_pkg::*;
#(
    parameter int SUB_W = 9,
    parameter int TILES = 3,
    parameter int ACC_W = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [TILES*TILES*SUB_W-1:0] a,
    input  logic [TILES*TILES*SUB_W-1:0] b,
    input  logic                         a_sign,
    input  logic                         b_sign,
    input  logic                         mode,
    input  logic                         acc_en,
    input  logic                         acc_clear,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             result,
    output logic                         acc_ovf
);

    localparam int LANES  = TILES * TILES;
    localparam int PP_W   = 2 * SUB_W;
    localparam int PROD_W = prod_w(SUB_W, TILES);
    localparam int DOT_W  = dot_w(SUB_W, TILES);

    stage_ctrl_t              s1_ctrl;
    stage_ctrl_t              s2_ctrl;
    logic [LANES*SUB_W-1:0]   s1_a;
    logic [LANES*SUB_W-1:0]   s1_b;
    logic [LANES*PP_W-1:0]    pp;
    logic [LANES*PP_W-1:0]    s2_pp;
    logic [PROD_W-1:0]        full_term [LANES];
    logic [DOT_W-1:0]         dot_term  [LANES];
    logic [PROD_W-1:0]        full_sum;
    logic [DOT_W-1:0]         dot_sum;
    logic                     prod_signed;
    logic [ACC_W-1:0]         prod_ext;
    logic [ACC_W-1:0]         base;
    logic [ACC_W:0]           sum;
    logic                     add_ovf;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         acc_next;
    logic                     ovf_next;
    logic                     stall;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign result   = acc;

    for (genvar i = 0; i < TILES; i++) begin : g_row
        for (genvar j = 0; j < TILES; j++) begin : g_col
            localparam int   K     = i * TILES + j;
            localparam int   SH    = (i + j) * SUB_W;
            localparam logic TOP_A = (i == TILES - 1);
            localparam logic TOP_B = (j == TILES - 1);

            logic [SUB_W-1:0] x;
            logic [SUB_W-1:0] y;
            logic             x_sign;
            logic             y_sign;
            logic             p_signed;
            logic [PP_W-1:0]  part;

            // FULL pairs A tile i with B tile j; DOT pairs lane K with lane K.
            assign x      = (s1_ctrl.mode == MODE_DOT) ? s1_a[K*SUB_W +: SUB_W] : s1_a[i*SUB_W +: SUB_W];
            assign y      = (s1_ctrl.mode == MODE_DOT) ? s1_b[K*SUB_W +: SUB_W] : s1_b[j*SUB_W +: SUB_W];
            assign x_sign = s1_ctrl.a_sign & ((s1_ctrl.mode == MODE_DOT) | TOP_A);
            assign y_sign = s1_ctrl.b_sign & ((s1_ctrl.mode == MODE_DOT) | TOP_B);

            pirdsp_mul_sub #(.SUB_W(SUB_W)) u_mul (
                .x      (x),
                .y      (y),
                .x_sign (x_sign),
                .y_sign (y_sign),
                .p      (pp[K*PP_W +: PP_W])
            );

            // Signedness of a stored partial is re-derived from the S2 controls.
            assign part     = s2_pp[K*PP_W +: PP_W];
            assign p_signed = (s2_ctrl.mode == MODE_DOT)
                            ? (s2_ctrl.a_sign | s2_ctrl.b_sign)
                            : ((s2_ctrl.a_sign & TOP_A) | (s2_ctrl.b_sign & TOP_B));
            assign full_term[K] = {{(PROD_W-PP_W){p_signed & part[PP_W-1]}}, part} << SH;
            assign dot_term[K]  = {{(DOT_W-PP_W){p_signed & part[PP_W-1]}}, part};
        end
    end

    always_comb begin
        full_sum = '0;
        dot_sum  = '0;
        for (int k = 0; k < LANES; k++) begin
            full_sum = full_sum + full_term[k];
            dot_sum  = dot_sum + dot_term[k];
        end

        prod_signed = s2_ctrl.a_sign | s2_ctrl.b_sign;
        if (s2_ctrl.mode == MODE_DOT) begin
            prod_ext = {{(ACC_W-DOT_W){prod_signed & dot_sum[DOT_W-1]}}, dot_sum};
        end else begin
            prod_ext = {{(ACC_W-PROD_W){prod_signed & full_sum[PROD_W-1]}}, full_sum};
        end

        base = s2_ctrl.acc_clear ? '0 : acc;
        sum  = {1'b0, base} + {1'b0, prod_ext};
        // Signed beats overflow when like-signed operands yield an opposite-signed sum.
        add_ovf  = prod_signed
                 ? ((base[ACC_W-1] == prod_ext[ACC_W-1]) & (sum[ACC_W-1] != base[ACC_W-1]))
                 : sum[ACC_W];
        acc_next = s2_ctrl.acc_en ? sum[ACC_W-1:0] : prod_ext;
        ovf_next = (~s2_ctrl.acc_clear & acc_ovf) | (s2_ctrl.acc_en & add_ovf);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_ctrl   <= '0;
            s2_ctrl   <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
        end else if (!stall) begin
            s1_ctrl   <= '{in_valid, mode, a_sign, b_sign, acc_en, acc_clear};
            s2_ctrl   <= s1_ctrl;
            out_valid <= s2_ctrl.valid;
            if (s2_ctrl.valid) begin
                acc     <= acc_next;
                acc_ovf <= ovf_next;
            end
        end
    end

    // Datapath registers carry no reset; their stage valid qualifies them.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_a  <= a;
            s1_b  <= b;
            s2_pp <= pp;
        end
    end

endmodule
